// File: rtl/record_burst_gen.sv
// record_burst_gen: start-triggered AXI-Stream burst source of 256-bit depth records
module record_burst_gen #(
  parameter logic [63:0] TS_BASE    = 64'd1234567890123456789,
  parameter logic [63:0] TS_STEP    = 64'd1000,
  parameter logic [63:0] ID_BASE    = 64'd9876543210,
  parameter logic [31:0] PRICE_F32  = 32'h42C90000,
  parameter logic [31:0] QTY_F32    = 32'h3E800000,
  parameter logic [7:0]  SIDE_FIX   = 8'd1,
  parameter int          ALT_SIDE   = 1,
  parameter int          CNT_W      = 16,
  parameter int          GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             cfg_continuous,
  output logic [255:0]     m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] rec_count
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state;
  logic [63:0] k, ts;
  logic [CNT_W-1:0] cnt, beat, nb;
  logic [15:0] gap_cnt;
  function automatic logic [255:0] rec(input logic [63:0] t, input logic [63:0] n);
    return {56'd0, QTY_F32, PRICE_F32, (ALT_SIDE != 0) ? {7'd0, n[0]} : SIDE_FIX, ID_BASE + n, t};
  endfunction
  // beat index of the record following the one being accepted
  always_comb nb = m_axis_tlast ? '0 : beat + 1'b1;
  // burst sequencer: record index and timestamp accumulate across continuous bursts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rec_count     <= '0;
      k             <= '0;
      ts            <= '0;
      cnt           <= '0;
      beat          <= '0;
      gap_cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          rec_count <= '0;
          k         <= '0;
          ts        <= TS_BASE;
          if (cfg_count != '0) begin
            cnt           <= cfg_count;
            beat          <= '0;
            m_axis_tdata  <= rec(TS_BASE, 64'd0);
            m_axis_tlast  <= cfg_count == CNT_W'(1);
            m_axis_tvalid <= 1'b1;
            busy          <= 1'b1;
            state         <= SEND;
          end else done <= 1'b1;
        end
        SEND: if (m_axis_tready) begin
          rec_count    <= rec_count + 1'b1;
          k            <= k + 64'd1;
          ts           <= ts + TS_STEP;
          m_axis_tdata <= rec(ts + TS_STEP, k + 64'd1);
          beat         <= nb;
          m_axis_tlast <= nb == cnt - 1'b1;
          if (m_axis_tlast && !cfg_continuous) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
            state         <= IDLE;
          end else if (GAP_CYCLES != 0) begin
            m_axis_tvalid <= 1'b0;
            gap_cnt       <= 16'(GAP_CYCLES - 1);
            state         <= GAP;
          end
        end
        GAP: if (gap_cnt == '0) begin
          m_axis_tvalid <= 1'b1;
          state         <= SEND;
        end else gap_cnt <= gap_cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_record_burst_gen.sv
// tb_record_burst_gen: directed self-checking bench for record_burst_gen
module tb_record_burst_gen;
  localparam logic [63:0] TSB = 64'd1234567890123456789;
  localparam logic [63:0] IDB = 64'd9876543210;
  logic clk = 0, rst_n = 1, start = 0, start2 = 0, cont = 0, tready = 0;
  logic [15:0] cfg_count = 0;
  logic [255:0] tdata1, tdata2;
  logic tvalid1, tlast1, busy1, done1, tvalid2, tlast2, busy2, done2;
  logic [15:0] rc1, rc2;
  int checks = 0, failures = 0;
  logic [3:0] v;
  always #5 clk = ~clk;
  record_burst_gen u1 (.clk(clk), .rst_n(rst_n), .start(start), .cfg_count(cfg_count), .cfg_continuous(cont),
    .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(tready), .m_axis_tlast(tlast1),
    .busy(busy1), .done(done1), .rec_count(rc1));
  record_burst_gen #(.GAP_CYCLES(2)) u2 (.clk(clk), .rst_n(rst_n), .start(start2), .cfg_count(cfg_count),
    .cfg_continuous(cont), .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2), .m_axis_tready(tready),
    .m_axis_tlast(tlast2), .busy(busy2), .done(done2), .rec_count(rc2));
  function automatic logic [255:0] exp_rec(input int n);
    logic [63:0] kk = 64'(n);
    return {56'd0, 32'h3E800000, 32'h42C90000, 7'd0, kk[0], IDB + kk, TSB + kk * 64'd1000};
  endfunction
  task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic [15:0] n);
    cfg_count = n;
    start = 1;
    step();
    start = 0;
  endtask
  task automatic burst(input int cnt, input int beats, input logic [31:0] pat, input int rel);
    int idx = 0, dn = 0;
    for (int c = 0; c < 80 && dn == 0; c++) begin
      tready = pat[c % 32];
      start = (c == 1 && cnt > 1);
      if (c == 1) cfg_count = 16'd7;
      if (done1) dn++;
      else if (tvalid1) begin
        chk("tdata", tdata1, exp_rec(idx));
        chk("tlast", 256'(tlast1), 256'((idx % cnt) == cnt - 1));
        chk("busy", 256'(busy1), 256'd1);
        if (tready) begin
          idx++;
          if (idx == rel) cont = 0;
        end
      end
      step();
    end
    start = 0;
    chk("beats", 256'(idx), 256'(beats));
    chk("done_seen", 256'(dn), 256'd1);
    chk("done_width", 256'(done1), 256'd0);
    chk("idle_tvalid", 256'(tvalid1), 256'd0);
    chk("idle_busy", 256'(busy1), 256'd0);
    chk("rec_count", 256'(rc1), 256'(beats));
  endtask
  initial begin
    #1 rst_n = 0;
    #2;
    chk("rst_tdata", tdata1, 256'd0);
    chk("rst_tvalid", 256'(tvalid1), 256'd0);
    chk("rst_tlast", 256'(tlast1), 256'd0);
    chk("rst_busy", 256'(busy1), 256'd0);
    chk("rst_done", 256'(done1), 256'd0);
    chk("rst_count", 256'(rc1), 256'd0);
    step();
    step();
    rst_n = 1;
    step();
    tready = 1;
    pulse(16'd3);
    chk("first_valid", 256'(tvalid1), 256'd1);
    burst(3, 3, 32'hFFFFFFFF, -1);
    pulse(16'd3);
    burst(3, 3, 32'hFFFFFF32, -1);
    cont = 1;
    pulse(16'd2);
    burst(2, 6, 32'hFFFFFFFF, 5);
    tready = 1;
    pulse(16'd0);
    chk("zero_valid", 256'(tvalid1), 256'd0);
    chk("zero_busy", 256'(busy1), 256'd0);
    chk("zero_done", 256'(done1), 256'd1);
    step();
    chk("zero_done_end", 256'(done1), 256'd0);
    chk("zero_busy_end", 256'(busy1), 256'd0);
    cfg_count = 16'd2;
    start2 = 1;
    step();
    start2 = 0;
    for (int c = 0; c < 4; c++) begin
      v[c] = tvalid2;
      if (c == 3) begin
        chk("gap_tdata", tdata2, exp_rec(1));
        chk("gap_tlast", 256'(tlast2), 256'd1);
      end
      step();
    end
    chk("gap_pattern", 256'(v), 256'(4'b1001));
    chk("gap_done", 256'(done2), 256'd1);
    chk("gap_count", 256'(rc2), 256'd2);
    step();
    tready = 0;
    pulse(16'd4);
    step();
    chk("stall_valid", 256'(tvalid1), 256'd1);
    chk("stall_tdata", tdata1, exp_rec(0));
    #2 rst_n = 0;
    #1;
    chk("async_tvalid", 256'(tvalid1), 256'd0);
    chk("async_count", 256'(rc1), 256'd0);
    step();
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      chk("post_rst_done", 256'(done1), 256'd0);
      chk("post_rst_busy", 256'(busy1), 256'd0);
      step();
    end
    tready = 1;
    pulse(16'd1);
    burst(1, 1, 32'hFFFFFFFF, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/record_burst_gen.md
Name: record_burst_gen

Overview:
- Parametrised successor to the one-shot depth-record test source; sits at the head of the depth-parser pipeline in place of live market data.
- On a start pulse, emits a burst of cfg_count 256-bit depth records on AXI-Stream.
- Timestamp and update_id increment per record; side is fixed or alternating; inter-record gap is configurable.
- Optional continuous mode repeats bursts until released. tlast marks the last record of each burst.

Parameters:
- TS_BASE, 64'd1234567890123456789, ts_ns of record 0.
- TS_STEP, 64'd1000, ts_ns increment per record.
- ID_BASE, 64'd9876543210, update_id of record 0.
- PRICE_F32, 32'h42C90000, price field (100.5f), constant.
- QTY_F32, 32'h3E800000, qty field (0.25f), constant.
- SIDE_FIX, 8'd1, side value when ALT_SIDE=0.
- ALT_SIDE, 1, 1: side = record index bit 0 (0 = bid, 1 = ask); 0: side = SIDE_FIX.
- CNT_W, 16, width of cfg_count and rec_count.
- GAP_CYCLES, 0, idle cycles with tvalid low after each accepted record (0 = back-to-back).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle burst request; sampled only in IDLE.
- cfg_count  in  CNT_W  records per burst; captured at start.
- cfg_continuous  in  1  repeat bursts while high; sampled at each burst end.
- m_axis_tdata  out  256  record payload.
- m_axis_tvalid  out  1  AXIS valid.
- m_axis_tready  in  1  AXIS ready.
- m_axis_tlast  out  1  high on the last record of a burst.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of the run.
- rec_count  out  CNT_W  total records accepted since start; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release): state = IDLE; tdata = 0; tvalid = 0; tlast = 0; busy = 0; done = 0; rec_count = 0; record index k = 0.
- Record k layout, LSB first:
  - [63:0] = TS_BASE + k*TS_STEP, computed by accumulator, wraps mod 2^64.
  - [127:64] = ID_BASE + k, wraps mod 2^64.
  - [135:128] = side.
  - [167:136] = PRICE_F32.
  - [199:168] = QTY_F32.
  - [255:200] = 0.
- k is a 64-bit running index. It is cleared at start and is NOT cleared between bursts in continuous mode, so update_id stays monotonic.
- States and transitions:
  - IDLE: start=1 and cfg_count>0 -> latch count; SEND; busy=1; record 0 presented with tvalid=1 the next cycle. Latency start -> tvalid is 1 cycle.
  - IDLE: start=1 and cfg_count=0 -> no beat; done pulses the next cycle; busy stays 0.
  - SEND: tvalid held high. tdata and tlast stay stable until tvalid & tready; no retraction, no change while stalled.
    - On handshake, not last record: k++, rec_count++. If GAP_CYCLES=0, the next record is presented the next cycle with tvalid continuously high. Otherwise go to GAP with tvalid=0.
    - On handshake, last record of burst (tlast=1): if cfg_continuous=1, begin a new burst of the latched count (same rules). Otherwise go to IDLE; tvalid=0; busy=0; done=1 for one cycle.
  - GAP: down-counter of GAP_CYCLES cycles, then SEND with the next record.
- tlast = 1 iff the current beat index within the burst equals latched count - 1. cfg_count=1 gives tlast on every beat.
- start while busy is ignored; cfg_count changes mid-burst are ignored.
- Deasserting cfg_continuous mid-burst completes the current burst, then done.
- Reset asserted mid-burst: tvalid drops immediately; the partial burst is discarded, with no done pulse.

Test Plan:
- cfg_count=3, ALT_SIDE=1, tready=1, start pulse -> 3 consecutive beats starting the cycle after start; update_id 9876543210..9876543212; ts step 1000; side 0,1,0; tlast on beat 2 only; done one cycle after beat 2; rec_count=3.
- Same run with tready toggling randomly -> every beat's tdata/tlast is stable across stall cycles; exactly 3 handshakes; sequence unchanged.
- GAP_CYCLES=2, cfg_count=2 -> tvalid low for exactly 2 cycles between the handshakes.
- cfg_continuous=1, cfg_count=2, released after the 5th handshake -> 6 beats; tlast on beats 1, 3, 5; update_id continuous through ID_BASE+5; single done.
- cfg_count=0 start -> no tvalid; done pulses once; busy stays 0.
- rst_n asserted while tvalid=1 and stalled -> tvalid=0 asynchronously; after release, IDLE with rec_count=0 and no done.
